// File: rtl/controle_navegacao.sv
// Left-hand-rule maze navigation controller.
// Each decision cycle (AVALIA) samples the wall sensors and issues a left turn, a right turn
// or an advance request. It also tracks the robot heading and counts completed cell advances.
//
// Ports:
//   clockc3    - system clock, rising edge
//   reset      - synchronous, active-low reset
//   iniciar    - start/restart request, honoured only in PARADO or FIM
//   head/left  - wall ahead / wall on the left
//   chegou     - goal cell reached
//   mov_ack    - movement unit finished one cell advance
//   avancar    - advance request, high throughout AVANCA
//   giro_esq   - one-cycle left-turn pulse
//   giro_dir   - one-cycle right-turn pulse
//   orientacao - heading: 001 N, 010 O (west), 011 L (east), 100 S
//   passos     - completed advances, saturating
//   ocupado    - high in AVALIA, GIRA_E, GIRA_D, AVANCA
//   concluido  - high in FIM
//   erro       - high in ERRO
module controle_navegacao #(
  parameter int unsigned PW          = 8,
  parameter int unsigned MAX_PASSOS  = 200,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic          clockc3,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          head,
  input  logic          left,
  input  logic          chegou,
  input  logic          mov_ack,
  output logic          avancar,
  output logic          giro_esq,
  output logic          giro_dir,
  output logic [0:2]    orientacao,
  output logic [PW-1:0] passos,
  output logic          ocupado,
  output logic          concluido,
  output logic          erro
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TimerLast = TW'(ACK_TIMEOUT - 1);

  localparam logic [0:2] DirN = 3'b001;
  localparam logic [0:2] DirO = 3'b010;
  localparam logic [0:2] DirL = 3'b011;
  localparam logic [0:2] DirS = 3'b100;

  typedef enum logic [2:0] {
    StParado,
    StAvalia,
    StGiraE,
    StGiraD,
    StAvanca,
    StFim,
    StErro
  } estado_t;

  estado_t       estado_q;
  logic          virou_esq_q;
  logic [TW-1:0] timer_q;

  // Illegal headings fall back to N so orientacao always stays in the legal set.
  function automatic logic [0:2] rot_esq(input logic [0:2] h);
    case (h)
      DirN:    return DirO;
      DirO:    return DirS;
      DirS:    return DirL;
      DirL:    return DirN;
      default: return DirN;
    endcase
  endfunction

  function automatic logic [0:2] rot_dir(input logic [0:2] h);
    case (h)
      DirN:    return DirL;
      DirL:    return DirS;
      DirS:    return DirO;
      DirO:    return DirN;
      default: return DirN;
    endcase
  endfunction

  always_ff @(posedge clockc3) begin
    if (!reset) begin
      estado_q    <= StParado;
      orientacao  <= DirN;
      passos      <= '0;
      virou_esq_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      case (estado_q)
        StParado: begin
          if (iniciar) estado_q <= StAvalia;
        end
        StAvalia: begin
          if (chegou) begin
            estado_q <= StFim;
          end else if (32'(passos) >= MAX_PASSOS) begin
            estado_q <= StErro;
          end else if (!left && !virou_esq_q) begin
            // Only one left turn per cell, otherwise an open left would spin forever.
            estado_q <= StGiraE;
          end else if (head) begin
            estado_q <= StGiraD;
          end else begin
            estado_q <= StAvanca;
            timer_q  <= '0;
          end
        end
        StGiraE: begin
          orientacao  <= rot_esq(orientacao);
          virou_esq_q <= 1'b1;
          estado_q    <= StAvalia;
        end
        StGiraD: begin
          orientacao <= rot_dir(orientacao);
          estado_q   <= StAvalia;
        end
        StAvanca: begin
          // Ack takes precedence over a timeout in the same cycle.
          if (mov_ack) begin
            if (passos != '1) passos <= passos + 1'b1;
            virou_esq_q <= 1'b0;
            estado_q    <= StAvalia;
          end else if (timer_q == TimerLast) begin
            estado_q <= StErro;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StFim: begin
          if (iniciar) begin
            passos      <= '0;
            virou_esq_q <= 1'b0;
            estado_q    <= StAvalia;
          end
        end
        StErro: begin
          estado_q <= StErro;
        end
        default: begin
          estado_q <= StParado;
        end
      endcase
    end
  end

  assign avancar   = (estado_q == StAvanca);
  assign giro_esq  = (estado_q == StGiraE);
  assign giro_dir  = (estado_q == StGiraD);
  assign ocupado   = (estado_q == StAvalia) || (estado_q == StGiraE) ||
                     (estado_q == StGiraD)  || (estado_q == StAvanca);
  assign concluido = (estado_q == StFim);
  assign erro      = (estado_q == StErro);

endmodule

// File: tb/tb_controle_navegacao.sv
module tb_controle_navegacao;

  localparam int PW = 8;
  localparam int MaxPassos = 200;
  localparam int AckTimeout = 16;
  localparam logic [16:0] RstVec = {3'b000, 3'b001, 8'd0, 3'b000};

  logic clockc3 = 1'b0;
  logic reset, iniciar, head, left, chegou, mov_ack;

  logic          avancar, giro_esq, giro_dir, ocupado, concluido, erro;
  logic [0:2]    orientacao;
  logic [PW-1:0] passos;

  logic          avancar3, giro_esq3, giro_dir3, ocupado3, concluido3, erro3;
  logic [0:2]    orientacao3;
  logic [PW-1:0] passos3;

  logic [16:0] dut_vec, dut3_vec;
  assign dut_vec  = {avancar, giro_esq, giro_dir, orientacao, passos, ocupado, concluido, erro};
  assign dut3_vec = {avancar3, giro_esq3, giro_dir3, orientacao3, passos3, ocupado3,
                     concluido3, erro3};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clockc3 = ~clockc3;

  controle_navegacao #(.PW(PW), .MAX_PASSOS(MaxPassos), .ACK_TIMEOUT(AckTimeout)) u_dut (
    .clockc3(clockc3), .reset(reset), .iniciar(iniciar), .head(head), .left(left),
    .chegou(chegou), .mov_ack(mov_ack), .avancar(avancar), .giro_esq(giro_esq),
    .giro_dir(giro_dir), .orientacao(orientacao), .passos(passos), .ocupado(ocupado),
    .concluido(concluido), .erro(erro)
  );

  controle_navegacao #(.PW(PW), .MAX_PASSOS(3), .ACK_TIMEOUT(AckTimeout)) u_dut3 (
    .clockc3(clockc3), .reset(reset), .iniciar(iniciar), .head(head), .left(left),
    .chegou(chegou), .mov_ack(mov_ack), .avancar(avancar3), .giro_esq(giro_esq3),
    .giro_dir(giro_dir3), .orientacao(orientacao3), .passos(passos3), .ocupado(ocupado3),
    .concluido(concluido3), .erro(erro3)
  );

  // Reference model: heading as a compass index 0 N, 1 L, 2 S, 3 O (clockwise order).
  typedef enum int {MParado, MAvalia, MGiraE, MGiraD, MAvanca, MFim, MErro} m_t;
  m_t m_st;
  int m_dir, m_passos, m_wait;
  bit m_virou;

  task automatic model_update();
    if (!reset) begin
      m_st = MParado; m_dir = 0; m_passos = 0; m_wait = 0; m_virou = 0;
    end else begin
      case (m_st)
        MParado: if (iniciar) m_st = MAvalia;
        MAvalia: begin
          if (chegou) m_st = MFim;
          else if (m_passos >= MaxPassos) m_st = MErro;
          else if (!left && !m_virou) m_st = MGiraE;
          else if (head) m_st = MGiraD;
          else begin m_st = MAvanca; m_wait = 0; end
        end
        MGiraE: begin m_dir = (m_dir + 3) % 4; m_virou = 1; m_st = MAvalia; end
        MGiraD: begin m_dir = (m_dir + 1) % 4; m_st = MAvalia; end
        MAvanca: begin
          if (mov_ack) begin
            m_passos = (m_passos < 255) ? m_passos + 1 : 255;
            m_virou = 0;
            m_st = MAvalia;
          end else if (m_wait == AckTimeout - 1) m_st = MErro;
          else m_wait++;
        end
        MFim: if (iniciar) begin m_passos = 0; m_virou = 0; m_st = MAvalia; end
        default: m_st = MErro;
      endcase
    end
  endtask

  function automatic logic [16:0] exp_vec();
    logic [2:0] code;
    case (m_dir)
      0: code = 3'b001;
      1: code = 3'b011;
      2: code = 3'b100;
      default: code = 3'b010;
    endcase
    return {m_st == MAvanca, m_st == MGiraE, m_st == MGiraD, code, 8'(m_passos),
            m_st inside {MAvalia, MGiraE, MGiraD, MAvanca}, m_st == MFim, m_st == MErro};
  endfunction

  // One clock edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clockc3);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; iniciar = 1'b0; head = 1'b0; left = 1'b1; chegou = 1'b0; mov_ack = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b1; head = 1'b1; left = 1'b0; chegou = 1'b1; mov_ack = 1'b1;
    tick(); tick();
    n_cmp++;
    if (dut_vec !== RstVec) begin
      n_err++; $display("FAIL reset_main: got %h expected %h", dut_vec, RstVec);
    end
    n_cmp++;
    if (dut3_vec !== RstVec) begin
      n_err++; $display("FAIL reset_dut3: got %h expected %h", dut3_vec, RstVec);
    end
    reset = 1'b1; iniciar = 1'b0;
    tick();
    n_cmp++;
    if (dut_vec !== RstVec) begin
      n_err++; $display("FAIL reset_idle: got %h expected %h", dut_vec, RstVec);
    end
  endtask

  task automatic test_corredor();
    do_reset();
    head = 1'b0; left = 1'b1; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    n_cmp++;
    if ({ocupado, avancar} !== 2'b10) begin
      n_err++; $display("FAIL corr_avalia: got ocupado,avancar=%b expected 10", {ocupado, avancar});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (avancar !== 1'b1) begin
        n_err++; $display("FAIL corr_avancar_%0d: got %b expected 1", i, avancar);
      end
      if (i == 2) mov_ack = 1'b1;
    end
    tick();
    mov_ack = 1'b0;
    n_cmp++;
    if ({avancar, ocupado, orientacao, passos} !== {1'b0, 1'b1, 3'b001, 8'd1}) begin
      n_err++; $display("FAIL corr_ack: got av=%b oc=%b or=%b p=%0d expected 0 1 001 1",
                        avancar, ocupado, orientacao, passos);
    end
  endtask

  task automatic test_giro_esq();
    do_reset();
    head = 1'b0; left = 1'b0; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    n_cmp++;
    if ({giro_esq, orientacao} !== {1'b1, 3'b001}) begin
      n_err++; $display("FAIL gesq_pulse: got ge=%b or=%b expected 1 001", giro_esq, orientacao);
    end
    tick();
    n_cmp++;
    if ({giro_esq, orientacao, ocupado} !== {1'b0, 3'b010, 1'b1}) begin
      n_err++; $display("FAIL gesq_after: got ge=%b or=%b oc=%b expected 0 010 1",
                        giro_esq, orientacao, ocupado);
    end
    tick();
    n_cmp++;
    if (avancar !== 1'b1) begin
      n_err++; $display("FAIL gesq_avancar: got %b expected 1", avancar);
    end
    mov_ack = 1'b1;
    tick();
    mov_ack = 1'b0;
    n_cmp++;
    if (passos !== 8'd1) begin
      n_err++; $display("FAIL gesq_passos: got %0d expected 1", passos);
    end
    // virou_esq was cleared by the ack, so the open left is taken again.
    tick();
    n_cmp++;
    if (giro_esq !== 1'b1) begin
      n_err++; $display("FAIL gesq_again: got %b expected 1", giro_esq);
    end
  endtask

  task automatic test_giro_dir();
    logic [0:2] seq [4];
    seq = '{3'b011, 3'b100, 3'b010, 3'b001};
    do_reset();
    head = 1'b1; left = 1'b1; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({giro_dir, avancar} !== 2'b10) begin
        n_err++; $display("FAIL gdir_pulse_%0d: got gd,av=%b expected 10", i, {giro_dir, avancar});
      end
      tick();
      n_cmp++;
      if ({giro_dir, orientacao} !== {1'b0, seq[i]}) begin
        n_err++; $display("FAIL gdir_or_%0d: got gd=%b or=%b expected 0 %b",
                          i, giro_dir, orientacao, seq[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int n_av;
    do_reset();
    head = 1'b0; left = 1'b1; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    n_av = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (avancar === 1'b1) n_av++;
      if (erro === 1'b1) break;
    end
    n_cmp++;
    if ({n_av == AckTimeout, erro} !== 2'b11) begin
      n_err++; $display("FAIL tout_len: got avancar cycles=%0d erro=%b expected %0d 1",
                        n_av, erro, AckTimeout);
    end
    iniciar = 1'b1;
    tick(); tick(); tick();
    iniciar = 1'b0;
    n_cmp++;
    if ({erro, ocupado, concluido} !== 3'b100) begin
      n_err++; $display("FAIL tout_hold: got er,oc,co=%b expected 100", {erro, ocupado, concluido});
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++;
    if (dut_vec !== RstVec) begin
      n_err++; $display("FAIL tout_reset: got %h expected %h", dut_vec, RstVec);
    end
  endtask

  task automatic test_chegou();
    do_reset();
    head = 1'b0; left = 1'b0; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    left = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      mov_ack = 1'b1;
      tick();
      mov_ack = 1'b0;
    end
    chegou = 1'b1;
    tick();
    chegou = 1'b0;
    n_cmp++;
    if ({concluido, ocupado, passos, orientacao} !== {2'b10, 8'd5, 3'b010}) begin
      n_err++; $display("FAIL fim_state: got co=%b oc=%b p=%0d or=%b expected 1 0 5 010",
                        concluido, ocupado, passos, orientacao);
    end
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    n_cmp++;
    if ({concluido, ocupado, passos, orientacao} !== {2'b01, 8'd0, 3'b010}) begin
      n_err++; $display("FAIL fim_restart: got co=%b oc=%b p=%0d or=%b expected 0 1 0 010",
                        concluido, ocupado, passos, orientacao);
    end
  endtask

  task automatic test_max_passos();
    do_reset();
    head = 1'b0; left = 1'b1; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      mov_ack = 1'b1;
      tick();
      mov_ack = 1'b0;
    end
    tick();
    n_cmp++;
    if ({erro3, passos3, avancar3} !== {1'b1, 8'd3, 1'b0}) begin
      n_err++; $display("FAIL max3: got erro=%b passos=%0d av=%b expected 1 3 0",
                        erro3, passos3, avancar3);
    end
    n_cmp++;
    if ({erro, passos, avancar} !== {1'b0, 8'd3, 1'b1}) begin
      n_err++; $display("FAIL max200_early: got erro=%b passos=%0d av=%b expected 0 3 1",
                        erro, passos, avancar);
    end
    mov_ack = 1'b1;
    tick();
    mov_ack = 1'b0;
    for (int i = 4; i < MaxPassos; i++) begin
      tick();
      mov_ack = 1'b1;
      tick();
      mov_ack = 1'b0;
    end
    tick();
    n_cmp++;
    if ({erro, passos} !== {1'b1, 8'(MaxPassos)}) begin
      n_err++; $display("FAIL max200: got erro=%b passos=%0d expected 1 %0d",
                        erro, passos, MaxPassos);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    head = 1'b0; left = 1'b1; iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick(); tick();
    n_cmp++;
    if (avancar !== 1'b1) begin
      n_err++; $display("FAIL rmid_avancar: got %b expected 1", avancar);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++;
    if (dut_vec !== RstVec) begin
      n_err++; $display("FAIL rmid_reset: got %h expected %h", dut_vec, RstVec);
    end
    mov_ack = 1'b1;
    tick();
    mov_ack = 1'b0;
    n_cmp++;
    if (dut_vec !== RstVec) begin
      n_err++; $display("FAIL rmid_late_ack: got %h expected %h", dut_vec, RstVec);
    end
  endtask

  task automatic test_random();
    logic [16:0] e;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 99) != 0);
      iniciar = ($urandom_range(0, 3) == 0);
      head    = 1'($urandom);
      left    = 1'($urandom);
      chegou  = ($urandom_range(0, 19) == 0);
      mov_ack = ($urandom_range(0, 3) == 0);
      tick();
      e = exp_vec();
      n_cmp++;
      if (dut_vec !== e) begin
        n_err++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec, e);
      end
    end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; head = 1'b0; left = 1'b1; chegou = 1'b0; mov_ack = 1'b0;
    test_reset();
    test_corredor();
    test_giro_esq();
    test_giro_dir();
    test_timeout();
    test_chegou();
    test_max_passos();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controle_navegacao.md
Name: controle_navegacao

Overview:
Left-hand-rule maze navigation controller that sequences the advance datapath of the robot. Each decision cycle it samples the wall sensors. It then issues one of three commands: a left turn, a right turn, or an advance request. It also tracks the current heading (orientacao) and counts the completed steps. It sits between the sensor inputs and the movement/advance unit, which consumes avancar and orientacao.

Parameters:
PW, 8, width of the step counter passos
MAX_PASSOS, 200, step limit; reaching it in AVALIA forces ERRO
ACK_TIMEOUT, 16, cycles allowed for mov_ack while in AVANCA (must be >= 2)

Ports:
clockc3  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
iniciar  input  1  start/restart request; sampled only in PARADO or FIM
head  input  1  1 = wall directly ahead
left  input  1  1 = wall on the left
chegou  input  1  1 = goal cell reached
mov_ack  input  1  movement unit completed one cell advance
avancar  output  1  advance request, held high while in AVANCA
giro_esq  output  1  one-cycle left-turn pulse
giro_dir  output  1  one-cycle right-turn pulse
orientacao  output  [0:2]  heading: 001 N, 010 O (west), 011 L (east), 100 S
passos  output  [PW-1:0]  completed advances, saturating
ocupado  output  1  1 in AVALIA, GIRA_E, GIRA_D, AVANCA
concluido  output  1  1 in FIM
erro  output  1  1 in ERRO

Behaviour:
- Reset (reset==0 at a clockc3 edge) puts the block in state PARADO with: orientacao=001, passos=0, virou_esq=0, timer=0, and all 1-bit outputs 0.
- A reset asserted mid-operation takes effect at the next edge. For example, avancar drops in the cycle after reset is sampled.
- Outputs are decoded from the registered state and registers only. There is no combinational path from inputs to outputs.
- States are PARADO, AVALIA, GIRA_E, GIRA_D, AVANCA, FIM, ERRO.
- PARADO: waits. iniciar=1 -> AVALIA.
- AVALIA: single cycle. Exits in this priority order:
  1. chegou=1 -> FIM.
  2. passos>=MAX_PASSOS -> ERRO.
  3. left=0 and virou_esq=0 -> GIRA_E.
  4. head=1 -> GIRA_D.
  5. Otherwise -> AVANCA, with timer cleared.
- GIRA_E: single cycle with giro_esq=1. At the exit edge, orientacao rotates left (N->O, O->S, S->L, L->N) and virou_esq is set to 1. Next state is AVALIA.
- GIRA_D: single cycle with giro_dir=1. At the exit edge, orientacao rotates right (N->L, L->S, S->O, O->N). virou_esq is unchanged. Next state is AVALIA.
- AVANCA: avancar=1 and the timer increments each cycle.
  - mov_ack=1 -> passos+1 (saturating at all-ones), virou_esq=0, next state AVALIA.
  - If no ack by the cycle where timer==ACK_TIMEOUT-1 -> ERRO.
  - If ack and timeout occur in the same cycle, ack wins.
  - mov_ack outside AVANCA is ignored.
- FIM: concluido=1. iniciar=1 -> passos=0, virou_esq=0, orientacao kept, next state AVALIA.
- ERRO: erro=1. The state holds until reset; iniciar is ignored.
- iniciar is ignored in every state except PARADO and FIM.
- orientacao never takes a value outside {001, 010, 011, 100}.
- Latency:
  - iniciar sampled at edge k -> AVALIA during cycle k+1.
  - An open corridor gives avancar=1 from cycle k+2.
  - A left-open cell gives giro_esq at k+2, then AVALIA at k+3, then avancar from k+4 (if head=0).

Test Plan:
- Reset, then iniciar=1 with head=0, left=1, mov_ack returned 3 cycles after avancar -> avancar high exactly 3 cycles, passos=1, orientacao=001, back in AVALIA.
- left=0 with head=0, starting N -> giro_esq pulse for 1 cycle, orientacao=010, then avancar. After the ack, virou_esq=0 and passos=1.
- head=1, left=1, four consecutive AVALIA cycles -> four giro_dir pulses, orientacao sequence 011, 100, 010, 001, no avancar.
- mov_ack never asserted, ACK_TIMEOUT=16 -> avancar high for 16 cycles, then erro=1 and held. iniciar=1 has no effect. Reset gives erro=0, orientacao=001.
- chegou=1 on AVALIA after 5 steps -> concluido=1 with passos=5. iniciar=1 -> passos=0 with orientacao unchanged. Also, MAX_PASSOS=3 with an open corridor -> ERRO after the 3rd ack.
- reset=0 in the 2nd cycle of AVANCA -> avancar=0 the next cycle, all outputs at reset values, and a late mov_ack is ignored.
